// File: rtl/dram_pin_arbiter.sv
// Single owner of the CIM-DRAM pin bundle: arbitrates NMST masters and registers every pin.
// Ownership changes only after a drain plus a guard window of safe pin values; ROUT is synchronised.
module dram_pin_arbiter #(
  parameter int                NCORE     = 16,
  parameter int                NMST      = 3,
  parameter int                CTRL_W    = 18,
  parameter logic [CTRL_W-1:0] SAFE_CTRL = '0,
  parameter int                GUARD     = 4,
  parameter int                TMO       = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NMST-1:0]          REQ,
  input  logic [NMST-1:0]          MBSY,
  input  logic [NMST*CTRL_W-1:0]   M_CTRL,
  input  logic [NMST*NCORE-1:0]    M_RAD,
  input  logic [NMST*NCORE-1:0]    M_DIN,
  input  logic [NMST*NCORE-1:0]    M_LIM,
  input  logic [NCORE-1:0]         ROUT,
  output logic [NMST-1:0]          GNT,
  output logic [NMST-1:0]          ABORT,
  output logic [CTRL_W-1:0]        CTRL,
  output logic [NCORE-1:0]         RAD,
  output logic [NCORE-1:0]         DIN,
  output logic [NCORE-1:0]         LIM,
  output logic [NCORE-1:0]         ROUT_S,
  output logic                     TMO_ERR
);

  localparam int IW = (NMST > 1) ? $clog2(NMST) : 1;
  localparam int DW = $clog2(TMO);
  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DRAIN, S_GUARD} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic [NMST-1:0]   gnt_q, gnt_d;
  logic [NMST-1:0]   abort_q, abort_d;
  logic              tmo_err_q, tmo_err_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [NCORE-1:0]  rad_q, rad_d;
  logic [NCORE-1:0]  din_q, din_d;
  logic [NCORE-1:0]  lim_q, lim_d;
  logic [NCORE-1:0]  rout_meta_q, rout_s_q;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  int                cand;
  logic              owned;

  // Master 0 has absolute priority; the rest are scanned from the RR pointer, wrapping within 1..NMST-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    if (REQ[0]) begin
      win_found = 1'b1;
    end else begin
      for (int i = 0; i < NMST - 1; i++) begin
        cand = int'(rr_q) + i;
        if (cand >= NMST) cand = cand - (NMST - 1);
        if (!win_found && REQ[cand]) begin
          win_found = 1'b1;
          win_idx   = IW'(cand);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    dcnt_d    = dcnt_q;
    gcnt_d    = gcnt_q;
    abort_d   = '0;
    tmo_err_d = tmo_err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          owner_d = win_idx;
          if (win_idx != '0)
            rr_d = (int'(win_idx) == NMST - 1) ? IW'(1) : win_idx + IW'(1);
        end
      end
      S_GRANT: begin
        dcnt_d = '0;
        if (!REQ[owner_q] || (owner_q != '0 && REQ[0]))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!MBSY[owner_q]) begin
          state_d = S_GUARD;
          gcnt_d  = '0;
        end else if (dcnt_q == DW'(TMO - 1)) begin
          state_d          = S_GUARD;
          gcnt_d           = '0;
          abort_d[owner_q] = 1'b1;
          tmo_err_d        = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_GUARD: begin
        if (gcnt_q == GW'(GUARD - 1)) state_d = S_IDLE;
        else                          gcnt_d  = gcnt_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pins are derived from the next state so GNT and pin contents always change on the same edge.
  always_comb begin
    owned  = (state_d == S_GRANT) || (state_d == S_DRAIN);
    gnt_d  = '0;
    ctrl_d = SAFE_CTRL;
    rad_d  = '0;
    din_d  = '0;
    lim_d  = '0;
    if (owned) begin
      gnt_d  = NMST'(1) << owner_d;
      ctrl_d = M_CTRL[int'(owner_d)*CTRL_W +: CTRL_W];
      rad_d  = M_RAD[int'(owner_d)*NCORE +: NCORE];
      din_d  = M_DIN[int'(owner_d)*NCORE +: NCORE];
      lim_d  = M_LIM[int'(owner_d)*NCORE +: NCORE];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      rr_q        <= IW'(1);
      dcnt_q      <= '0;
      gcnt_q      <= '0;
      gnt_q       <= '0;
      abort_q     <= '0;
      tmo_err_q   <= 1'b0;
      ctrl_q      <= SAFE_CTRL;
      rad_q       <= '0;
      din_q       <= '0;
      lim_q       <= '0;
      rout_meta_q <= '0;
      rout_s_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      dcnt_q      <= dcnt_d;
      gcnt_q      <= gcnt_d;
      gnt_q       <= gnt_d;
      abort_q     <= abort_d;
      tmo_err_q   <= tmo_err_d;
      ctrl_q      <= ctrl_d;
      rad_q       <= rad_d;
      din_q       <= din_d;
      lim_q       <= lim_d;
      rout_meta_q <= ROUT;
      rout_s_q    <= rout_meta_q;
    end
  end

  assign GNT     = gnt_q;
  assign ABORT   = abort_q;
  assign TMO_ERR = tmo_err_q;
  assign CTRL    = ctrl_q;
  assign RAD     = rad_q;
  assign DIN     = din_q;
  assign LIM     = lim_q;
  assign ROUT_S  = rout_s_q;

endmodule

// File: tb/tb_dram_pin_arbiter.sv
// Bench for dram_pin_arbiter: per-cycle expectations pushed to a scoreboard when driven,
// popped and compared one cycle later against the registered outputs.
module tb_dram_pin_arbiter;

  localparam int NCORE = 16;
  localparam int NMST  = 3;
  localparam int CW    = 18;
  localparam logic [CW-1:0] SAFE = 18'h15A5A;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic [NMST-1:0]       REQ, MBSY;
  logic [NMST*CW-1:0]    M_CTRL;
  logic [NMST*NCORE-1:0] M_RAD, M_DIN, M_LIM;
  logic [NCORE-1:0]      ROUT;
  logic [NMST-1:0]       GNT, ABORT;
  logic [CW-1:0]         CTRL;
  logic [NCORE-1:0]      RAD, DIN, LIM, ROUT_S;
  logic                  TMO_ERR;

  dram_pin_arbiter #(
    .NCORE(NCORE), .NMST(NMST), .CTRL_W(CW), .SAFE_CTRL(SAFE), .GUARD(4), .TMO(1024)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .MBSY(MBSY), .M_CTRL(M_CTRL),
    .M_RAD(M_RAD), .M_DIN(M_DIN), .M_LIM(M_LIM), .ROUT(ROUT),
    .GNT(GNT), .ABORT(ABORT), .CTRL(CTRL), .RAD(RAD), .DIN(DIN), .LIM(LIM),
    .ROUT_S(ROUT_S), .TMO_ERR(TMO_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]       gnt;
    logic [2:0]       abort;
    logic             tmo;
    logic [CW-1:0]    ctrl;
    logic [NCORE-1:0] rad, din, lim, rout;
  } exp_t;

  typedef struct {
    logic [2:0] req;
    logic [2:0] mbsy;
    logic [2:0] gnt;
  } vec_t;

  exp_t             sb[$];
  vec_t             tbl[26];
  int               n_chk  = 0;
  int               n_fail = 0;
  int               n_step = 0;
  logic [NCORE-1:0] rout_last = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, n_step, act, exp);
    end
  endfunction

  task automatic step(input logic rst, input logic [2:0] req, input logic [2:0] mbsy,
                      input logic [2:0] egnt, input logic [2:0] eabort, input logic etmo,
                      input string tag);
    exp_t e;
    int   own;
    RST  = rst;
    REQ  = req;
    MBSY = mbsy;
    for (int m = 0; m < NMST; m++) begin
      M_CTRL[m*CW +: CW]       = CW'($urandom);
      M_RAD[m*NCORE +: NCORE]  = NCORE'($urandom);
      M_DIN[m*NCORE +: NCORE]  = NCORE'($urandom);
      M_LIM[m*NCORE +: NCORE]  = NCORE'($urandom);
    end
    ROUT = NCORE'($urandom);
    own = -1;
    for (int m = 0; m < NMST; m++) if (egnt[m]) own = m;
    e.gnt   = egnt;
    e.abort = eabort;
    e.tmo   = etmo;
    if (own < 0) begin
      e.ctrl = SAFE;
      e.rad  = '0;
      e.din  = '0;
      e.lim  = '0;
    end else begin
      e.ctrl = M_CTRL[own*CW +: CW];
      e.rad  = M_RAD[own*NCORE +: NCORE];
      e.din  = M_DIN[own*NCORE +: NCORE];
      e.lim  = M_LIM[own*NCORE +: NCORE];
    end
    e.rout    = rst ? '0 : rout_last;
    rout_last = rst ? '0 : ROUT;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    n_step++;
    check({tag, ".gnt"},   32'(GNT),     32'(e.gnt));
    check({tag, ".abort"}, 32'(ABORT),   32'(e.abort));
    check({tag, ".tmo"},   32'(TMO_ERR), 32'(e.tmo));
    check({tag, ".ctrl"},  32'(CTRL),    32'(e.ctrl));
    check({tag, ".rad"},   32'(RAD),     32'(e.rad));
    check({tag, ".din"},   32'(DIN),     32'(e.din));
    check({tag, ".lim"},   32'(LIM),     32'(e.lim));
    check({tag, ".rout"},  32'(ROUT_S),  32'(e.rout));
    $display("step %0d %s rst=%b req=%b mbsy=%b gnt=%b abort=%b tmo=%b rad=%h rout_s=%h",
             n_step, tag, rst, req, mbsy, GNT, ABORT, TMO_ERR, RAD, ROUT_S);
    @(negedge CLK);
  endtask

  // One round-robin transfer: grant, two held cycles (no preemption), drop, 1-cycle drain, guard + idle.
  task automatic xfer(input logic [2:0] m_oh);
    step(1'b0, 3'b110, m_oh, m_oh, 3'b000, 1'b0, "rr_grant");
    step(1'b0, 3'b110, m_oh, m_oh, 3'b000, 1'b0, "rr_hold");
    step(1'b0, 3'b110, m_oh, m_oh, 3'b000, 1'b0, "rr_hold");
    step(1'b0, 3'b110 & ~m_oh, 3'b000, m_oh, 3'b000, 1'b0, "rr_drop");
    step(1'b0, 3'b110, 3'b000, 3'b000, 3'b000, 1'b0, "rr_drain");
    repeat (4) step(1'b0, 3'b110, 3'b000, 3'b000, 3'b000, 1'b0, "rr_guard");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout step %0d: simulation did not finish", n_step);
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{3'b010, 3'b010, 3'b010};
    tbl[1]  = '{3'b010, 3'b010, 3'b010};
    tbl[2]  = '{3'b011, 3'b010, 3'b010};
    tbl[3]  = '{3'b011, 3'b010, 3'b010};
    tbl[4]  = '{3'b011, 3'b010, 3'b010};
    tbl[5]  = '{3'b011, 3'b000, 3'b000};
    tbl[6]  = '{3'b100, 3'b000, 3'b000};
    tbl[7]  = '{3'b011, 3'b000, 3'b000};
    tbl[8]  = '{3'b011, 3'b000, 3'b000};
    tbl[9]  = '{3'b011, 3'b000, 3'b000};
    tbl[10] = '{3'b011, 3'b000, 3'b001};
    tbl[11] = '{3'b011, 3'b001, 3'b001};
    tbl[12] = '{3'b010, 3'b001, 3'b001};
    tbl[13] = '{3'b010, 3'b000, 3'b000};
    tbl[14] = '{3'b010, 3'b000, 3'b000};
    tbl[15] = '{3'b010, 3'b000, 3'b000};
    tbl[16] = '{3'b010, 3'b000, 3'b000};
    tbl[17] = '{3'b010, 3'b000, 3'b000};
    tbl[18] = '{3'b010, 3'b000, 3'b010};
    tbl[19] = '{3'b000, 3'b000, 3'b010};
    tbl[20] = '{3'b000, 3'b000, 3'b000};
    tbl[21] = '{3'b000, 3'b000, 3'b000};
    tbl[22] = '{3'b000, 3'b000, 3'b000};
    tbl[23] = '{3'b000, 3'b000, 3'b000};
    tbl[24] = '{3'b000, 3'b000, 3'b000};
    tbl[25] = '{3'b000, 3'b000, 3'b000};

    RST = 1'b1; REQ = '0; MBSY = '0; ROUT = '0;
    M_CTRL = '0; M_RAD = '0; M_DIN = '0; M_LIM = '0;
    @(negedge CLK);

    // Reset values, grant latency, preemption by master 0, guard window, RR wrap, 1-cycle drain.
    step(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, "reset");
    for (int i = 0; i < 26; i++)
      step(1'b0, tbl[i].req, tbl[i].mbsy, tbl[i].gnt, 3'b000, 1'b0, "table");

    // Round-robin between masters 1 and 2 with both requesting.
    step(1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, "reset_rr");
    xfer(3'b010);
    xfer(3'b100);
    xfer(3'b010);

    // Drain watchdog: owner releases REQ but stays busy for the full limit.
    step(1'b0, 3'b010, 3'b010, 3'b010, 3'b000, 1'b0, "wd_grant");
    step(1'b0, 3'b000, 3'b010, 3'b010, 3'b000, 1'b0, "wd_enter");
    for (int k = 0; k < 1023; k++)
      step(1'b0, 3'b000, 3'b010, 3'b010, 3'b000, 1'b0, "wd_drain");
    step(1'b0, 3'b000, 3'b010, 3'b000, 3'b010, 1'b1, "wd_abort");
    repeat (4) step(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, "wd_guard");

    // Reset in the middle of a grant clears everything, including the sticky flag.
    step(1'b0, 3'b001, 3'b001, 3'b001, 3'b000, 1'b1, "mid_grant");
    step(1'b1, 3'b001, 3'b001, 3'b000, 3'b000, 1'b0, "mid_reset");
    step(1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
